// File: rtl/hlsm_job_sequencer.sv
// Job sequencer: queues {a,b,c} operand sets and runs each one through an
// external HLSM datapath (start/done handshake) with a WAIT timeout abort.
module hlsm_job_sequencer #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_a,
    input  logic signed [WIDTH-1:0]     in_b,
    input  logic signed [WIDTH-1:0]     in_c,
    output logic                        hlsm_start,
    output logic signed [WIDTH-1:0]     hlsm_a,
    output logic signed [WIDTH-1:0]     hlsm_b,
    output logic signed [WIDTH-1:0]     hlsm_c,
    input  logic                        hlsm_done,
    input  logic signed [WIDTH-1:0]     hlsm_z,
    input  logic signed [WIDTH-1:0]     hlsm_x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH-1:0]     out_z,
    output logic signed [WIDTH-1:0]     out_x,
    output logic                        out_err,
    output logic                        busy,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    // state  | meaning
    // IDLE   | waiting for a queued job; pops the FIFO head when one exists
    // LAUNCH | hlsm_start high for this single cycle
    // WAIT   | waiting for a done rising edge or the timeout
    // EMIT   | result held on out_* until out_ready

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nx;

    logic [3*WIDTH-1:0]      r_mem [DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;

    logic                    r_hlsm_start;
    logic signed [WIDTH-1:0] r_hlsm_a;
    logic signed [WIDTH-1:0] r_hlsm_b;
    logic signed [WIDTH-1:0] r_hlsm_c;
    logic                    r_done_q;
    logic [TW-1:0]           r_wait_cnt;

    logic                    r_out_valid;
    logic signed [WIDTH-1:0] r_out_z;
    logic signed [WIDTH-1:0] r_out_x;
    logic                    r_out_err;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_done_rise;
    logic                    w_complete;
    logic                    w_abort;
    logic                    w_ack;

    assign in_ready    = Rst && (r_count < CW'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_done_rise = hlsm_done && !r_done_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Completion is tested ahead of the timeout so it wins a same-cycle tie.
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_complete = 1'b0;
        w_abort    = 1'b0;
        w_ack      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_rise) begin
                    w_complete = 1'b1;
                    w_state_nx = S_EMIT;
                end else if (r_wait_cnt == TW'(TIMEOUT)) begin
                    w_abort    = 1'b1;
                    w_state_nx = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_ack      = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_a, in_b, in_c};
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_hlsm_start <= 1'b0;
            r_hlsm_a     <= '0;
            r_hlsm_b     <= '0;
            r_hlsm_c     <= '0;
            r_done_q     <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_hlsm_start <= w_pop;
            r_done_q     <= hlsm_done;
            if (w_pop) begin
                {r_hlsm_a, r_hlsm_b, r_hlsm_c} <= r_mem[r_rd_ptr];
            end
            if (r_state == S_WAIT && w_state_nx == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + TW'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_out_valid <= 1'b0;
            r_out_z     <= '0;
            r_out_x     <= '0;
            r_out_err   <= 1'b0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_z     <= hlsm_z;
            r_out_x     <= hlsm_x;
            r_out_err   <= 1'b0;
        end else if (w_abort) begin
            r_out_valid <= 1'b1;
            r_out_z     <= '0;
            r_out_x     <= '0;
            r_out_err   <= 1'b1;
        end else if (w_ack) begin
            r_out_valid <= 1'b0;
        end
    end

    assign hlsm_start = r_hlsm_start;
    assign hlsm_a     = r_hlsm_a;
    assign hlsm_b     = r_hlsm_b;
    assign hlsm_c     = r_hlsm_c;
    assign out_valid  = r_out_valid;
    assign out_z      = r_out_z;
    assign out_x      = r_out_x;
    assign out_err    = r_out_err;
    assign busy       = (r_state != S_IDLE);
    assign count      = r_count;

endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// Bench for hlsm_job_sequencer: job-level reference model (FIFO queue of jobs,
// queue of expected results, datapath responder), directed table and random traffic.
module tb_hlsm_job_sequencer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int T  = 63;
    localparam int CW = $clog2(D + 1);

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_a, in_b, in_c;
    logic                 hlsm_start;
    logic signed [W-1:0]  hlsm_a, hlsm_b, hlsm_c;
    logic                 hlsm_done;
    logic signed [W-1:0]  hlsm_z, hlsm_x;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  out_z, out_x;
    logic                 out_err;
    logic                 busy;
    logic [CW-1:0]        count;

    hlsm_job_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .hlsm_start(hlsm_start), .hlsm_a(hlsm_a), .hlsm_b(hlsm_b), .hlsm_c(hlsm_c),
        .hlsm_done(hlsm_done), .hlsm_z(hlsm_z), .hlsm_x(hlsm_x),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_x(out_x), .out_err(out_err),
        .busy(busy), .count(count)
    );

    always #5 Clk = ~Clk;

    // delay: cycles from start to the done pulse, 0 = never, -1 = done driven by the test
    typedef struct {
        logic signed [W-1:0] a, b, c;
        int                  delay;
        bit                  hold_err;
    } job_t;

    typedef struct {
        logic signed [W-1:0] z, x;
        bit                  err;
    } res_t;

    typedef struct {
        logic signed [W-1:0] a, b, c;
        int                  delay;
        logic signed [W-1:0] ez, ex;
        bit                  eerr;
    } vec_t;

    job_t fifo_q[$];
    res_t res_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   inflight, due_valid, pend, hold_mode, start_seen, last_acc;
    int   due_cyc, pend_cyc;
    job_t cur_job;
    int   drv_delay;
    bit   drv_hold_err;

    function automatic logic signed [W-1:0] fz(input logic signed [W-1:0] a, b, c);
        return a * c + a + b;
    endfunction

    function automatic logic signed [W-1:0] fx(input logic signed [W-1:0] a, b);
        return (a * b) & 32'sd15;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endtask

    task automatic tick();
        bit   acc, ack, rst_edge, hold_pre;
        job_t j;
        res_t r;
        logic signed [W-1:0] pz, px;
        bit   perr;
        #1;
        acc      = in_valid && Rst && (fifo_q.size() < D);
        ack      = out_valid && out_ready && Rst;
        hold_pre = out_valid && !out_ready && Rst;
        rst_edge = !Rst;
        pz = out_z; px = out_x; perr = out_err;
        chk("in_ready", in_ready, (Rst && fifo_q.size() < D));
        j.a = in_a; j.b = in_b; j.c = in_c; j.delay = drv_delay; j.hold_err = drv_hold_err;
        @(posedge Clk);
        #1;
        cyc++;
        last_acc = acc;
        if (rst_edge) begin
            fifo_q.delete();
            res_q.delete();
            inflight = 0; due_valid = 0; pend = 0;
        end else begin
            if (acc) begin
                fifo_q.push_back(j);
                if (!inflight && fifo_q.size() == 1) begin
                    due_valid = 1; due_cyc = cyc + 1; inflight = 1;
                end
            end
            if (ack) begin
                if (res_q.size() == 0) begin
                    fail_now("spurious_result");
                end else begin
                    r = res_q.pop_front();
                    chk("res_z", pz, r.z);
                    chk("res_x", px, r.x);
                    chk("res_err", {31'd0, perr}, {31'd0, r.err});
                end
                inflight = 0;
                if (fifo_q.size() > 0) begin
                    due_valid = 1; due_cyc = cyc + 1; inflight = 1;
                end
            end
            if (hlsm_start) begin
                chk("start_time", cyc, due_valid ? due_cyc : -1);
                due_valid = 0;
                start_seen = 1;
                if (fifo_q.size() == 0) begin
                    fail_now("start_without_job");
                end else begin
                    cur_job = fifo_q.pop_front();
                    chk("launch_a", hlsm_a, cur_job.a);
                    chk("launch_b", hlsm_b, cur_job.b);
                    chk("launch_c", hlsm_c, cur_job.c);
                    if (cur_job.delay < 0) r.err = cur_job.hold_err;
                    else r.err = (cur_job.delay == 0) || (cur_job.delay > T + 1);
                    r.z = r.err ? '0 : fz(cur_job.a, cur_job.b, cur_job.c);
                    r.x = r.err ? '0 : fx(cur_job.a, cur_job.b);
                    res_q.push_back(r);
                    pend = (cur_job.delay > 0);
                    pend_cyc = cyc + cur_job.delay;
                end
            end else if (due_valid && cyc > due_cyc) begin
                fail_now("start_missing");
                due_valid = 0;
            end
            if (hold_pre) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_z", out_z, pz);
                chk("hold_x", out_x, px);
                chk("hold_err", {31'd0, out_err}, {31'd0, perr});
            end
        end
        chk("count", count, fifo_q.size());
        if (!hold_mode) begin
            if (pend && cyc == pend_cyc) begin
                hlsm_done = 1'b1;
                hlsm_z = fz(cur_job.a, cur_job.b, cur_job.c);
                hlsm_x = fx(cur_job.a, cur_job.b);
                pend = 0;
                if (cur_job.delay <= T + 1) chk("operands_stable", hlsm_a, cur_job.a);
            end else begin
                hlsm_done = 1'b0;
                hlsm_z = $urandom;
                hlsm_x = $urandom;
            end
        end else begin
            hlsm_z = fz(cur_job.a, cur_job.b, cur_job.c);
            hlsm_x = fx(cur_job.a, cur_job.b);
        end
    endtask

    task automatic push(input logic signed [W-1:0] a, b, c, input int d, input bit he);
        in_valid = 1'b1; in_a = a; in_b = b; in_c = c; drv_delay = d; drv_hold_err = he;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input string nm);
        int n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        if (!out_valid) fail_now(nm);
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!start_seen && n < 50) begin
            tick();
            n++;
        end
        if (!start_seen) fail_now(nm);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        out_ready = 1'b1;
        while ((fifo_q.size() != 0 || inflight || res_q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (fifo_q.size() != 0 || inflight || res_q.size() != 0) fail_now(nm);
    endtask

    vec_t vt[6];

    initial begin
        int sent;
        vt[0] = '{a:5,    b:7,   c:3,  delay:4,  ez:27,  ex:3,  eerr:0};
        vt[1] = '{a:-2,   b:10,  c:5,  delay:1,  ez:-2,  ex:12, eerr:0};
        vt[2] = '{a:100,  b:-3,  c:2,  delay:64, ez:297, ex:4,  eerr:0};
        vt[3] = '{a:9,    b:9,   c:9,  delay:65, ez:0,   ex:0,  eerr:1};
        vt[4] = '{a:-7,   b:-8,  c:-1, delay:0,  ez:0,   ex:0,  eerr:1};
        vt[5] = '{a:1,    b:2,   c:3,  delay:2,  ez:6,   ex:2,  eerr:0};

        Rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
        out_ready = 1'b1; hlsm_done = 1'b0; hlsm_z = '0; hlsm_x = '0;
        hold_mode = 0; drv_delay = 4; drv_hold_err = 0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_start", hlsm_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", out_err, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_hlsm_a", hlsm_a, 0);
        Rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            push(vt[i].a, vt[i].b, vt[i].c, vt[i].delay, 0);
            wait_ov("table_timeout");
            chk("tbl_z", out_z, vt[i].ez);
            chk("tbl_x", out_x, vt[i].ex);
            chk("tbl_err", out_err, vt[i].eerr);
            chk("tbl_busy", busy, 1);
            tick();
        end

        // fill while stalled in EMIT, then push on the same cycle as a pop
        out_ready = 1'b0;
        push(11, 12, 13, 2, 0);
        wait_ov("fill_first");
        for (int i = 0; i < 5; i++) begin
            push(20 + i, 30 + i, 40 + i, 3, 0);
            if (i == 3) begin
                chk("full_ready", in_ready, 0);
                chk("full_count", count, 4);
            end
        end
        chk("full_count_after_5th", count, 4);
        repeat (10) tick();
        chk("stall_valid", out_valid, 1);
        chk("stall_z", out_z, fz(11, 12, 13));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_ov("fill_second");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pre_pushpop_count", count, 3);
        push(-50, 60, -70, 3, 0);
        chk("count_push_pop", count, 3);
        drain("fill_drain");

        // done held high across two jobs
        hold_mode = 1; start_seen = 0;
        push(3, 4, 5, -1, 0);
        push(6, 7, 8, -1, 1);
        wait_start("sticky_start");
        tick(); tick();
        hlsm_done = 1'b1;
        wait_ov("sticky_first");
        chk("sticky1_err", out_err, 0);
        chk("sticky1_z", out_z, fz(3, 4, 5));
        tick();
        wait_ov("sticky_second");
        chk("sticky2_err", out_err, 1);
        chk("sticky2_z", out_z, 0);
        tick();
        hlsm_done = 1'b0;
        drain("sticky_drain");
        hold_mode = 0;

        // reset in WAIT with two jobs still queued
        start_seen = 0;
        push(1, 1, 1, 0, 0);
        push(2, 2, 2, 0, 0);
        push(3, 3, 3, 0, 0);
        wait_start("reset_start");
        repeat (5) tick();
        chk("pre_reset_count", count, 2);
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_start", hlsm_start, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (100) tick();
        chk("post_rst_valid", out_valid, 0);

        // random traffic
        sent = 0;
        for (int k = 0; k < 8000 && sent < 40; k++) begin
            int r;
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = $urandom; in_b = $urandom_range(0, 2000) - 1000; in_c = $urandom;
            r = $urandom_range(0, 9);
            if (r == 0) drv_delay = 0;
            else if (r == 1) drv_delay = $urandom_range(T, T + 3);
            else drv_delay = $urandom_range(1, 8);
            drv_hold_err = 0;
            tick();
            if (last_acc) sent++;
        end
        in_valid = 1'b0;
        chk("rand_jobs_sent", sent, 40);
        drain("rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hlsm_job_sequencer.md
HLSM_JOB_SEQUENCER -- requirements
Module: hlsm_job_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width (signed).
REQ-002 SHALL have parameter DEPTH, default 4, operand-FIFO entries (power of 2, at least 2).
REQ-003 SHALL have parameter TIMEOUT, default 63, maximum WAIT cycles before abort.
REQ-004 SHALL have these ports:
- Clk  in  1  sole clock, rising edge.
- Rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  job offered.
- in_ready  out  1  FIFO can accept a job.
- in_a, in_b, in_c  in  WIDTH  job operands, signed.
- hlsm_start  out  1  Start pulse to the HLSM datapath.
- hlsm_a, hlsm_b, hlsm_c  out  WIDTH  operands driven to the datapath.
- hlsm_done  in  1  datapath Done.
- hlsm_z, hlsm_x  in  WIDTH  datapath results.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_z, out_x  out  WIDTH  captured results.
- out_err  out  1  result is a timeout abort.
- busy  out  1  FSM not in IDLE.
- count  out  clog2(DEPTH+1)  FIFO occupancy.

Function
REQ-005 SHALL hold jobs {a,b,c} in a DEPTH-entry FIFO; in_ready = (count < DEPTH).
REQ-006 SHALL push on in_valid & in_ready; push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
REQ-007 SHALL ignore in_valid while full, with no overwrite and no count change.
REQ-008 SHALL implement FSM states IDLE, LAUNCH, WAIT, EMIT.
REQ-009 IDLE: if count != 0, SHALL pop the head, register it onto hlsm_a/b/c, and go to LAUNCH; otherwise SHALL stay in IDLE.
REQ-010 LAUNCH: SHALL drive hlsm_start=1 for exactly this one cycle, then go to WAIT unconditionally.
REQ-011 SHALL hold hlsm_a/b/c stable from LAUNCH until the FSM leaves WAIT.
REQ-012 SHALL register hlsm_done every cycle into done_q; completion is hlsm_done & ~done_q, sampled in WAIT only.
REQ-013 A rising edge of hlsm_done outside WAIT SHALL be ignored.
REQ-014 WAIT: on completion, SHALL capture out_z=hlsm_z, out_x=hlsm_x, out_err=0, set out_valid, and go to EMIT.
REQ-015 WAIT: SHALL count cycles from 0; when the count reaches TIMEOUT without completion, SHALL set out_z=0, out_x=0, out_err=1, set out_valid, and go to EMIT.
REQ-016 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-017 EMIT: SHALL hold out_valid, out_z, out_x and out_err stable until out_ready.
REQ-018 EMIT: on out_ready, SHALL clear out_valid next cycle and go to IDLE, with no bubble-skipping.
REQ-019 Latency: a job pushed into an empty FIFO while in IDLE SHALL see hlsm_start high exactly 2 cycles after the push cycle.
REQ-020 Back-to-back: a queued job SHALL see hlsm_start exactly 2 cycles after the out_ready handshake of the previous job.
REQ-021 SHALL keep results in FIFO order; exactly one result per popped job.
REQ-022 busy = (state != IDLE).
REQ-023 The FIFO SHALL accept pushes in every FSM state.

Reset
REQ-024 When Rst=0 at a clock edge, SHALL set: state IDLE, count 0, pointers 0, hlsm_start 0, hlsm_a/b/c 0, done_q 0, WAIT counter 0, out_valid 0, out_z/out_x 0, out_err 0.
REQ-025 While Rst=0, in_ready SHALL be 0.
REQ-026 Reset mid-operation SHALL discard all queued and in-flight jobs and emit no result for them.

Verification
REQ-027 Single job: push a=5, b=7, c=3 into empty FIFO; model responds with done edge 4 cycles after start, z=27, x=3 -> start 2 cycles after push; out_valid with out_z=27, out_x=3, out_err=0.
REQ-028 Fill: push 5 jobs with the FSM stalled in EMIT (out_ready=0), DEPTH=4 -> in_ready=0 after 4th accept; 5th not stored; count=4; results emitted later in push order.
REQ-029 Timeout: hlsm_done held 0 -> after TIMEOUT cycles in WAIT, out_valid=1, out_err=1, out_z=out_x=0; next job launches normally.
REQ-030 Sticky done: hlsm_done held 1 across two jobs -> first job completes on the edge; second job times out (out_err=1).
REQ-031 Backpressure/simultaneity: out_ready=0 for 10 cycles -> out_* stable; push on the same cycle as a pop -> count unchanged.
REQ-032 Reset mid-WAIT with 2 jobs queued: Rst=0 for 1 cycle -> count=0, out_valid=0, hlsm_start=0, no result emitted afterwards.
